// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// Grants capture the winner's byte, pulse tx_start, wait for tx_done, then hold
// off the next arbitration for gap_cycles idle cycles.
// Optional watchdog (define UART_ARB_TIMEOUT_EN) abandons a transfer whose
// tx_done never arrives and raises a sticky timeout_err.
module uart_tx_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DW     = 8,
  parameter int unsigned GAP_DW = 8,
  parameter int unsigned TO_DW  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 tx_start,
  output logic [DW-1:0]        tx_data,
  input  logic                 tx_done,
  input  logic [GAP_DW-1:0]    gap_cycles,
  input  logic [TO_DW-1:0]     timeout_cycles,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWaitDone,
    StGap
  } state_e;

  state_e              state_q, state_d;
  logic [LW-1:0]       last_q, last_d;
  logic [LW-1:0]       owner_q, owner_d;
  logic [DW-1:0]       tx_data_q, tx_data_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic                tx_start_q, tx_start_d;
  logic [GAP_DW-1:0]   gap_cnt_q, gap_cnt_d;

  logic                win_found;
  logic [LW-1:0]       win_idx;
  logic [LW-1:0]       cand;

`ifdef UART_ARB_TIMEOUT_EN
  logic [TO_DW-1:0]    to_cnt_q, to_cnt_d;
  logic                to_err_q, to_err_d;
  logic                to_hit;

  // Fires on the edge that ends the timeout_cycles-th WAIT_DONE cycle.
  assign to_hit = (timeout_cycles != '0) && (to_cnt_q == timeout_cycles - TO_DW'(1));
`else
  logic                unused_timeout;

  assign unused_timeout = ^timeout_cycles;
`endif

  // Round-robin search: first asserted request starting just after last_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = LW'((32'(last_q) + i) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic for the arbitration FSM.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    tx_data_d  = tx_data_q;
    gnt_d      = '0;
    done_d     = '0;
    tx_start_d = 1'b0;
    gap_cnt_d  = gap_cnt_q;
`ifdef UART_ARB_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    to_err_d   = to_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          tx_data_d  = req_data[win_idx*DW +: DW];
          owner_d    = win_idx;
          gnt_d      = NREQ'(1) << win_idx;
          tx_start_d = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
          state_d    = StWaitDone;
        end
      end
      StWaitDone: begin
        if (tx_done) begin
          done_d    = NREQ'(1) << owner_q;
          last_d    = owner_q;
          gap_cnt_d = gap_cycles;
          state_d   = StGap;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (to_hit) begin
          // Abandon the frame silently; owner still counts as served.
          to_err_d  = 1'b1;
          last_d    = owner_q;
          gap_cnt_d = gap_cycles;
          state_d   = StGap;
        end else if (to_cnt_q != '1) begin
          to_cnt_d  = to_cnt_q + TO_DW'(1);
        end
`endif
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_DW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any in-flight frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_q     <= LW'(NREQ - 1);
      owner_q    <= '0;
      tx_data_q  <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      tx_start_q <= 1'b0;
      gap_cnt_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_q   <= '0;
      to_err_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      tx_data_q  <= tx_data_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      tx_start_q <= tx_start_d;
      gap_cnt_q  <= gap_cnt_d;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      to_err_q   <= to_err_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != StIdle);
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = to_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares one UART transmitter among `NREQ` byte-producing requesters using round-robin arbitration.
- Sits between the requesters and the transmitter's `tx_start`/`tx_data`/`tx_done` interface.
- Captures the winning byte, issues the transmitter's start pulse, waits for completion, then enforces a programmable inter-frame gap before the next arbitration.
- An optional watchdog aborts a transfer whose `tx_done` never arrives.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `DW`, 8, data width per byte
- `GAP_DW`, 8, width of the gap counter and the `gap_cycles` port
- `TO_DW`, 16, width of the watchdog counter and the `timeout_cycles` port

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  per-requester request; level, held until granted
- `req_data`  in  NREQ*DW  byte of requester i at bits [i*DW +: DW]; stable while `req[i]` is high
- `gnt`  out  NREQ  one-hot, one-cycle pulse: byte captured
- `done`  out  NREQ  one-hot, one-cycle pulse: owner's byte fully transmitted
- `tx_start`  out  1  one-cycle start pulse to the transmitter
- `tx_data`  out  DW  registered byte; held from grant until the next grant
- `tx_done`  in  1  transmitter completion pulse
- `gap_cycles`  in  GAP_DW  idle cycles inserted after each frame
- `timeout_cycles`  in  TO_DW  watchdog limit; 0 disables the watchdog
- `busy`  out  1  high in any state other than IDLE
- `timeout_err`  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, WAIT_DONE, GAP.
- **IDLE**
  - If `|req`, select winner `w` as the first asserted index searching from `last+1` upward, wrapping modulo `NREQ`.
  - Register `tx_data <= req_data[w]`, `owner <= w`, `gnt <= onehot(w)`, `tx_start <= 1`.
  - Go to WAIT_DONE.
- **WAIT_DONE**
  - On `tx_done`: `done[owner]` pulses, `last <= owner`, load gap counter with `gap_cycles`, go to GAP.
  - `req` is ignored in this state.
- **GAP**
  - Counter decrements each cycle; leave for IDLE when it equals 0.
  - With `gap_cycles==0`, exit to IDLE on the cycle after entry.
- `tx_done` is ignored in IDLE and GAP.
- `last` resets to `NREQ-1`, so requester 0 has first priority after reset.
- Granted requester:
  - may drop `req` the cycle after `gnt`, or keep it high to queue its next byte;
  - it competes again only after the round-robin pointer passes it.
- A `req` dropped before grant is simply not seen. No error is raised.

## Timing
- Reset values: `gnt=0`, `done=0`, `tx_start=0`, `tx_data=0`, `busy=0`, `timeout_err=0`, state IDLE, `last=NREQ-1`, all counters 0.
- Reset asserted mid-transfer returns to IDLE immediately. No `done` is issued for the in-flight byte.
- Latency: `req` sampled high at edge k (state IDLE) gives `gnt` and `tx_start` high for exactly the cycle after edge k.
- `done` is high the cycle after the edge that samples `tx_done`.
- Back-to-back, `gap_cycles=G`: consecutive `tx_start` pulses are separated by transmitter time + G + 3 cycles.
  - The 3 fixed cycles are: done-sample, GAP exit, IDLE arbitration.
- `tx_start` is never asserted outside the cycle after IDLE-with-request.
- `gnt` and `done` are each single-bit-hot or all-zero in every cycle.
- Counters are unsigned and do not wrap. The gap counter stops at 0.

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- **Defined:**
  - In WAIT_DONE a counter increments from 0 each cycle.
  - If `timeout_cycles!=0` and the counter reaches `timeout_cycles` without `tx_done`, the transfer is abandoned:
    - no `done` is issued;
    - `timeout_err <= 1` (cleared only by reset);
    - `last <= owner`;
    - go to GAP.
  - If `tx_done` and the timeout occur in the same cycle, `tx_done` wins.
- **Undefined:**
  - The `timeout_cycles` port is present but ignored.
  - `timeout_err` is tied to 0.
  - WAIT_DONE waits indefinitely.

## Test plan
- Reset, then `req=4'b0001`, `req_data[7:0]=8'hA5` → `gnt=0001` and `tx_start` one cycle later, `tx_data=A5`; after `tx_done`, `done=0001`.
- `req=4'b1111` held, `gap_cycles=0`, model returns `tx_done` 10 cycles after each start → grant order 0,1,2,3,0; starts spaced 13 cycles.
- `req=4'b1010` after requester 1 was served last → requester 3 granted next, then requester 1.
- `gap_cycles=5`, request pending during GAP → no `tx_start` until 5 GAP cycles elapse; `busy` high throughout.
- With `UART_ARB_TIMEOUT_EN`, `timeout_cycles=20`, `tx_done` never sent → abort after 20 cycles, no `done`, `timeout_err=1`, next requester is granted. Repeat with `tx_done` on cycle 20 exactly → `done` issued, `timeout_err` stays 0.
- Assert `rst` in WAIT_DONE → all outputs 0 immediately; after release, requester 0 wins first.
